// File: rtl/ps2_key_decoder_if.sv
// PS/2 keyboard lines plus decoded key/scan outputs between a keyboard host and the decoder.
interface ps2_key_decoder_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [4:0] KEY_PRESSED;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output PS2_CLK,
    output PS2_DAT,
    input  KEY_PRESSED,
    input  scan_code,
    input  scan_valid,
    input  frame_err
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DAT,
    output KEY_PRESSED,
    output scan_code,
    output scan_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 receiver: synchronises the keyboard lines, frames bytes, tracks E0/F0
// prefixes and turns make codes of the game keys into one-cycle KEY_PRESSED pulses.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT     = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              CLOCK_50,
  input logic              reset,
  ps2_key_decoder_if.slave bus
);

  localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned KEY_W    = 5;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned BITCNT_W = 3;
  localparam logic [KEY_W-1:0]  KEY_NONE = KEY_W'(31);
  localparam logic [BYTE_W-1:0] CODE_EXT = BYTE_W'(8'hE0);
  localparam logic [BYTE_W-1:0] CODE_BRK = BYTE_W'(8'hF0);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   clk_fall;

  rx_state_t            state;
  logic [BITCNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0]    shift_reg;
  logic                 par_bit;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 ext;
  logic                 brk;
  logic [KEY_W-1:0]     key_q;
  logic [BYTE_W-1:0]    scan_code_q;
  logic                 scan_valid_q;
  logic                 frame_err_q;

  // Set 2 code to game key; anything not listed maps to KEY_NONE.
  function automatic logic [KEY_W-1:0] key_decode(input logic [BYTE_W-1:0] code,
                                                  input logic ext_f);
    logic [KEY_W-1:0] k;
    k = KEY_NONE;
    case ({ext_f, code})
      9'h01D: k = KEY_W'(0);
      9'h01B: k = KEY_W'(1);
      9'h01C: k = KEY_W'(2);
      9'h023: k = KEY_W'(3);
      9'h175: k = KEY_W'(4);
      9'h172: k = KEY_W'(5);
      9'h16B: k = KEY_W'(6);
      9'h174: k = KEY_W'(7);
      9'h043: k = KEY_W'(8);
      9'h042: k = KEY_W'(9);
      9'h03B: k = KEY_W'(10);
      9'h04B: k = KEY_W'(11);
      9'h075: k = KEY_W'(12);
      9'h073: k = KEY_W'(13);
      9'h06B: k = KEY_W'(14);
      9'h074: k = KEY_W'(15);
      9'h029: k = KEY_W'(16);
      default: k = KEY_NONE;
    endcase
    return k;
  endfunction

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  assign clk_fall = clk_prev & ~clk_s;

  // Synchronisers preset to the idle-high line level so release never fakes an edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync[0] <= bus.PS2_CLK;
      dat_sync[0] <= bus.PS2_DAT;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        clk_sync[i] <= clk_sync[i-1];
        dat_sync[i] <= dat_sync[i-1];
      end
      clk_prev <= clk_s;
    end
  end

  // Frame receiver, timeout, prefix tracking and key decode.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_bit      <= 1'b0;
      tmo_cnt      <= '0;
      ext          <= 1'b0;
      brk          <= 1'b0;
      key_q        <= KEY_NONE;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      key_q        <= KEY_NONE;

      if (clk_fall || state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      if (clk_fall) begin
        case (state)
          IDLE: begin
            if (!dat_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          DATA: begin
            shift_reg <= {dat_s, shift_reg[BYTE_W-1:1]};
            bit_cnt   <= bit_cnt + BITCNT_W'(1);
            if (bit_cnt == BITCNT_W'(BYTE_W - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= dat_s;
            state   <= STOP;
          end
          STOP: begin
            if (dat_s && (^{shift_reg, par_bit})) begin
              scan_code_q  <= shift_reg;
              scan_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tmo_cnt == TMO_W'(TIMEOUT)) begin
        state       <= IDLE;
        frame_err_q <= 1'b1;
      end

      // Byte accepted last cycle: update prefixes or emit the key.
      if (scan_valid_q) begin
        if (scan_code_q == CODE_EXT) begin
          ext <= 1'b1;
        end else if (scan_code_q == CODE_BRK) begin
          brk <= 1'b1;
        end else begin
          if (!brk) begin
            key_q <= key_decode(scan_code_q, ext);
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end

      if (frame_err_q) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  assign bus.KEY_PRESSED = key_q;
  assign bus.scan_code   = scan_code_q;
  assign bus.scan_valid  = scan_valid_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: frames are bit-banged on the PS/2 lines and
// expected scan bytes, keys and frame errors are matched against DUT pulses.
module tb_ps2_key_decoder;

  localparam int unsigned TB_TIMEOUT = 200;
  localparam int unsigned HALF       = 10;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .TIMEOUT     (TB_TIMEOUT),
    .SYNC_STAGES (2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [7:0] exp_scan[$];
  logic [4:0] exp_key[$];
  int         err_pending = 0;
  int         tests_run   = 0;
  int         tests_failed = 0;

  logic       prev_valid = 1'b0;
  logic [7:0] mon_scan;
  logic [4:0] mon_key;

  // Scoreboard monitor: every DUT pulse must match the head of its queue.
  always @(negedge CLOCK_50) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.scan_valid === 1'b1) begin
        tests_run++;
        if (exp_scan.size() == 0) begin
          tests_failed++;
          $display("FAIL scan_unexpected: got scan_code %02h, expected no scan_valid", bus.scan_code);
        end else begin
          mon_scan = exp_scan.pop_front();
          if (bus.scan_code !== mon_scan) begin
            tests_failed++;
            $display("FAIL scan_code: got %02h expected %02h", bus.scan_code, mon_scan);
          end
        end
      end
      if (bus.KEY_PRESSED !== 5'd31) begin
        tests_run++;
        if (prev_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL key_timing: got KEY_PRESSED %0d not one cycle after scan_valid", bus.KEY_PRESSED);
        end else if (exp_key.size() == 0) begin
          tests_failed++;
          $display("FAIL key_unexpected: got KEY_PRESSED %0d expected 31", bus.KEY_PRESSED);
        end else begin
          mon_key = exp_key.pop_front();
          if (bus.KEY_PRESSED !== mon_key) begin
            tests_failed++;
            $display("FAIL key_value: got %0d expected %0d", bus.KEY_PRESSED, mon_key);
          end
        end
      end
      if (bus.frame_err === 1'b1) begin
        tests_run++;
        if (err_pending == 0) begin
          tests_failed++;
          $display("FAIL frame_err_unexpected: got frame_err 1 expected 0");
        end else begin
          err_pending--;
        end
      end
      prev_valid = bus.scan_valid;
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    bus.PS2_DAT = b;
    wait_cyc(HALF);
    bus.PS2_CLK = 1'b0;
    wait_cyc(HALF);
    bus.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ flip_par;
    if (!flip_par && !bad_stop) exp_scan.push_back(b);
    else err_pending++;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    wait_cyc(HALF);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(b[i]);
    bus.PS2_DAT = 1'b1;
  endtask

  task automatic check_drained(input string name);
    wait_cyc(8);
    tests_run++;
    if (exp_scan.size() != 0 || exp_key.size() != 0 || err_pending != 0) begin
      tests_failed++;
      $display("FAIL %s: got pending scan=%0d key=%0d err=%0d expected all 0",
               name, exp_scan.size(), exp_key.size(), err_pending);
    end
    exp_scan.delete();
    exp_key.delete();
    err_pending = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    wait_cyc(3);
    tests_run += 4;
    if (bus.KEY_PRESSED !== 5'd31) begin
      tests_failed++; $display("FAIL reset_key: got %0d expected 31", bus.KEY_PRESSED);
    end
    if (bus.scan_code !== 8'h00) begin
      tests_failed++; $display("FAIL reset_scan_code: got %02h expected 00", bus.scan_code);
    end
    if (bus.scan_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_scan_valid: got %b expected 0", bus.scan_valid);
    end
    if (bus.frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err);
    end
    reset = 1'b0;
    wait_cyc(5);
    check_drained("reset_quiet");
  endtask

  task automatic test_single_make();
    exp_key.push_back(5'd0);
    send_good(8'h1D);
    check_drained("make_1d");
    exp_key.push_back(5'd3);
    send_good(8'h23);
    exp_key.push_back(5'd11);
    send_good(8'h4B);
    check_drained("make_23_4b");
  endtask

  task automatic test_extended();
    exp_key.push_back(5'd4);
    send_good(8'hE0);
    send_good(8'h75);
    check_drained("ext_75");
    exp_key.push_back(5'd12);
    send_good(8'h75);
    check_drained("keypad_75");
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    check_drained("ext_break_75");
    exp_key.push_back(5'd12);
    send_good(8'h75);
    check_drained("flags_cleared");
  endtask

  task automatic test_break();
    send_good(8'hF0);
    send_good(8'h1D);
    check_drained("break_1d");
    exp_key.push_back(5'd16);
    send_good(8'h29);
    check_drained("start_29");
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1, 1'b0);
    exp_key.push_back(5'd2);
    send_good(8'h1C);
    check_drained("parity_1c");
    send_good(8'hE0);
    send_frame(8'h33, 1'b1, 1'b0);
    exp_key.push_back(5'd12);
    send_good(8'h75);
    check_drained("err_clears_ext");
  endtask

  task automatic test_framing_errors();
    send_frame(8'h1D, 1'b0, 1'b1);
    check_drained("bad_stop");
    err_pending++;
    ps2_bit(1'b1);
    wait_cyc(HALF);
    check_drained("bad_start");
    exp_key.push_back(5'd9);
    send_good(8'h42);
    check_drained("after_bad_start");
  endtask

  task automatic test_timeout();
    err_pending++;
    send_partial(8'h43, 5);
    wait_cyc(TB_TIMEOUT + 20);
    check_drained("timeout_err");
    exp_key.push_back(5'd8);
    send_good(8'h43);
    check_drained("after_timeout");
  endtask

  task automatic test_reset_midframe();
    send_partial(8'hE0, 4);
    reset = 1'b1;
    wait_cyc(3);
    tests_run += 2;
    if (bus.KEY_PRESSED !== 5'd31) begin
      tests_failed++; $display("FAIL midreset_key: got %0d expected 31", bus.KEY_PRESSED);
    end
    if (bus.frame_err !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_frame_err: got %b expected 0", bus.frame_err);
    end
    reset = 1'b0;
    wait_cyc(5);
    exp_key.push_back(5'd15);
    send_good(8'h74);
    check_drained("after_midreset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      exp_key.push_back(5'd0);
      send_good(8'h1D);
    end
    check_drained("typematic");
    send_good(8'h5A);
    send_good(8'hE0);
    send_good(8'h1D);
    check_drained("unmapped");
    exp_key.push_back(5'd7);
    send_good(8'hE0);
    send_good(8'h74);
    exp_key.push_back(5'd14);
    send_good(8'h6B);
    check_drained("mixed_seq");
  endtask

  initial begin
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    test_reset();
    test_single_make();
    test_extended();
    test_break();
    test_parity();
    test_framing_errors();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter: TIMEOUT, default 50000, CLOCK_50 cycles with no PS2_CLK falling edge before a partial frame is abandoned (1 ms).
REQ-002 Parameter: SYNC_STAGES, default 2, synchroniser depth on PS2_CLK and PS2_DAT.
REQ-003 CLOCK_50  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PS2_CLK  input  1  keyboard clock, asynchronous, idle high.
REQ-006 PS2_DAT  input  1  keyboard data, asynchronous, idle high.
REQ-007 KEY_PRESSED  output  5  game key code; 0-15 = player direction, 16 = start, 31 = no key.
REQ-008 scan_code  output  8  last correctly framed byte, for debug.
REQ-009 scan_valid  output  1  one-cycle pulse when scan_code updates.
REQ-010 frame_err  output  1  one-cycle pulse on a discarded frame (bad start, parity, stop, or timeout).

Function
REQ-011 PS2_CLK and PS2_DAT SHALL each pass through SYNC_STAGES flops; a falling edge is synced-clock 1 in the previous cycle and 0 in the current cycle.
REQ-012 Receive FSM states: IDLE, DATA, PARITY, STOP; all transitions occur only on a detected falling edge, except timeout and reset.
REQ-013 IDLE: sampled data 0 -> DATA with bit counter cleared; sampled data 1 -> stay in IDLE and pulse frame_err.
REQ-014 DATA: shift sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-015 PARITY: store the bit; odd parity over 8 data bits plus parity bit is required; -> STOP.
REQ-016 STOP: sampled 1 with good parity accepts the byte and gives scan_code/scan_valid the next cycle; otherwise pulse frame_err; -> IDLE either way.
REQ-017 Timeout counter: cleared on every falling edge; counts while the FSM is not in IDLE; on reaching TIMEOUT -> IDLE with frame_err pulsed; saturates, never wraps.
REQ-018 Prefix flags ext and brk: accepted byte E0 sets ext; accepted byte F0 sets brk; any other accepted byte is decoded and then both flags are cleared.
REQ-019 frame_err SHALL clear ext and brk.
REQ-020 Decode (Set 2, ext=0 unless noted):
- P1: 1D->0, 1B->1, 1C->2, 23->3
- P2 (ext=1): 75->4, 72->5, 6B->6, 74->7
- P3: 43->8, 42->9, 3B->10, 4B->11
- P4 (ext=0, keypad): 75->12, 73->13, 6B->14, 74->15
- 29->16 (start)
REQ-021 A decoded code with brk=0 SHALL appear on KEY_PRESSED for exactly one cycle, one cycle after scan_valid; otherwise KEY_PRESSED = 31.
REQ-022 A decoded byte with brk=1, and any unmapped byte, SHALL produce no KEY_PRESSED pulse.
REQ-023 Typematic repeats (repeated make codes) SHALL each produce a new one-cycle pulse.
REQ-024 Minimum spacing between KEY_PRESSED pulses follows from framing: at least 11 PS2_CLK periods; no queueing is required.

Reset
REQ-025 While reset is high: FSM = IDLE; bit counter, shift register, timeout counter, ext and brk = 0; KEY_PRESSED = 31; scan_code = 00; scan_valid = 0; frame_err = 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse; the first falling edge after release is treated as a start bit.
REQ-027 Synchroniser flops SHALL reset to 1 so no spurious edge is seen on release.

Verification
REQ-028 Frame 1D (good parity) -> scan_valid pulse with scan_code=1D, then KEY_PRESSED=0 for one cycle, then 31.
REQ-029 Frames E0,75 -> KEY_PRESSED=4 once; frame 75 alone -> KEY_PRESSED=12 once; frames E0,F0,75 -> no pulse, ext/brk cleared.
REQ-030 Frames F0,1D -> no KEY_PRESSED pulse; next frame 29 -> KEY_PRESSED=16.
REQ-031 Frame 1C with parity bit flipped -> frame_err pulse, no scan_valid; following good 1C -> KEY_PRESSED=2.
REQ-032 Stop PS2_CLK after 5 data bits for TIMEOUT cycles -> frame_err pulse, FSM IDLE; next full frame 43 -> KEY_PRESSED=8.
REQ-033 Assert reset after bit 4 of frame E0 -> KEY_PRESSED=31, no frame_err; next full frame 74 after release -> KEY_PRESSED=15.
